// File: rtl/shift_pkg.sv
// Shared constants and types for the iterative shifters beside the ALU.
package shift_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W     = 5;
  localparam int SHAMT_MAX = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shr_step.sv
// Single-position right shift: fill enters at the MSB, bit 0 falls out.
module shr_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted,
  output logic             out_bit
);

  assign shifted = {fill, value[WIDTH-1:1]};
  assign out_bit = value[0];

endmodule

// File: rtl/seq_shift_right.sv
// Iterative right shifter, one position per clock, start/done handshake.
// Sign-fill is compiled in only when SHR_ARITH_EN is defined.
module seq_shift_right
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             arith,
  input  logic             start,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_ld;
  logic [WIDTH-1:0]   work, work_nx;
  logic               cout_w, step_out;
  logic               fill;

  // Shift amounts at or beyond the width all behave like a full-width shift.
  assign cnt_ld = (b >= WIDTH'(SHAMT_MAX)) ? CNT_W'(SHAMT_MAX) : b[CNT_W-1:0];

`ifdef SHR_ARITH_EN
  logic arith_q;
  always_ff @(posedge clk) begin
    if (rst)                         arith_q <= 1'b0;
    else if (state == IDLE && start) arith_q <= arith;
  end
  assign fill = arith_q & work[WIDTH-1];
`else
  logic unused_arith;
  assign unused_arith = arith;
  assign fill = 1'b0;
`endif

  shr_step #(.WIDTH(WIDTH)) u_step (
    .value   (work),
    .fill    (fill),
    .shifted (work_nx),
    .out_bit (step_out)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // cout_w tracks the latest shifted-out bit; the visible cout only moves at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      work   <= '0;
      cout_w <= 1'b0;
      s      <= '0;
      cout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work   <= a;
            cnt    <= cnt_ld;
            cout_w <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            work   <= work_nx;
            cout_w <= step_out;
            cnt    <= cnt - CNT_W'(1);
          end else begin
            s    <= work;
            cout <= cout_w;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_seq_shift_right.sv
// Directed bench for seq_shift_right; a monitor pops expected results on done.
module tb_seq_shift_right;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        arith = 1'b0, start = 1'b0;
  logic [15:0] s;
  logic        cout, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    int          lat;
    int          issue;
    string       name;
  } exp_t;

  exp_t sb[$];

  seq_shift_right dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .arith(arith), .start(start),
    .s(s), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (busy) begin
        errors++;
        $display("FAIL busy_with_done: busy=%0b done=%0b, required busy=0", busy, done);
      end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 3;
        if (s !== e.s) begin
          errors++;
          $display("FAIL %s_s: got %h, required %h", e.name, s, e.s);
        end
        if (cout !== e.c) begin
          errors++;
          $display("FAIL %s_cout: got %b, required %b", e.name, cout, e.c);
        end
        if (cyc - e.issue != e.lat) begin
          errors++;
          $display("FAIL %s_latency: got %0d, required %0d", e.name, cyc - e.issue, e.lat);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input string name, input logic [15:0] ia, input logic [15:0] ib,
                       input logic iarith, input logic [15:0] es, input logic ec, input int lat);
    exp_t e;
    a = ia; b = ib; arith = iarith; start = 1'b1;
    e.s = es; e.c = ec; e.lat = lat; e.issue = cyc + 1; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: pending=%0d, required 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check1("reset_s", s, 16'h0000);
    check1("reset_cout", {15'd0, cout}, 16'd0);
    check1("reset_busy", {15'd0, busy}, 16'd0);
    check1("reset_done", {15'd0, done}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Logical shift by 3, with busy observed across the operation.
    issue("lsr3", 16'hB4F1, 16'd3, 1'b0, 16'h169E, 1'b0, 4);
    check1("lsr3_busy1", {15'd0, busy}, 16'd1);
    @(negedge clk);
    check1("lsr3_busy2", {15'd0, busy}, 16'd1);
    @(negedge clk);
    check1("lsr3_busy3", {15'd0, busy}, 16'd1);
    wait_drain("lsr3");
    check1("lsr3_hold_s", s, 16'h169E);

`ifdef SHR_ARITH_EN
    issue("asr3", 16'hB4F1, 16'd3, 1'b1, 16'hF69E, 1'b0, 4);
    wait_drain("asr3");
    issue("asr_sat", 16'h8001, 16'd20, 1'b1, 16'hFFFF, 1'b1, 17);
`else
    issue("asr3", 16'hB4F1, 16'd3, 1'b1, 16'h169E, 1'b0, 4);
    wait_drain("asr3");
    issue("asr_sat", 16'h8001, 16'd20, 1'b1, 16'h0000, 1'b1, 17);
`endif
    wait_drain("asr_sat");
    issue("lsr_sat", 16'h8001, 16'd20, 1'b0, 16'h0000, 1'b1, 17);
    wait_drain("lsr_sat");

    issue("b0", 16'h1234, 16'd0, 1'b0, 16'h1234, 1'b0, 1);
    wait_drain("b0");
    issue("b1", 16'h0001, 16'd1, 1'b0, 16'h0000, 1'b1, 2);
    wait_drain("b1");

    // Start while busy is ignored; start in the done cycle is accepted.
    issue("busy_ign", 16'h00F0, 16'd4, 1'b0, 16'h000F, 1'b0, 5);
    a = 16'hFFFF; b = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL busy_ign_done: done=%b, required 1", done);
    end
    issue("done_cyc", 16'h8000, 16'd15, 1'b0, 16'h0001, 1'b0, 16);
    check1("done_cyc_busy", {15'd0, busy}, 16'd1);
    wait_drain("done_cyc");

    // Reset mid-operation: no done, outputs cleared, then normal operation.
    issue("rst_mid", 16'hFFFF, 16'd10, 1'b0, 16'h0000, 1'b0, 11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check1("rst_mid_s", s, 16'h0000);
    check1("rst_mid_cout", {15'd0, cout}, 16'd0);
    check1("rst_mid_busy", {15'd0, busy}, 16'd0);
    repeat (12) @(negedge clk);
    issue("post_rst", 16'h00F0, 16'd2, 1'b0, 16'h003C, 1'b0, 3);
    wait_drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
